// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: sequential wrapper around the combinational MULT32 array.
// Registers operand magnitudes, waits LATENCY cycles for the ripple array to
// settle, then captures the sign-corrected 64-bit product into HI/LO.
// Also handles MTHI/MTLO moves and drives BUSY/DONE for the pipeline.
// Optional feature: define MULT_ACC_EN to enable MADD/MADDU accumulation.

module hilo_mult_ctrl #(
   parameter int unsigned LATENCY = 4  // settle cycles, legal 1..15
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        SIGNED,
   input  logic [31:0] RS,
   input  logic [31:0] RT,
   input  logic        FLUSH,
   input  logic        MTHI,
   input  logic        MTLO,
   input  logic [31:0] WDATA,
   input  logic        ACC,
   output logic [31:0] MUL_OP1,
   output logic [31:0] MUL_OP2,
   input  logic [31:0] MUL_HI,
   input  logic [31:0] MUL_LO,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [3:0] CntInit = 4'(LATENCY - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        neg_q;
   logic [31:0] op1_q, op2_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q, done_q;

   logic [31:0] op1_d, op2_d;
   logic        neg_d;
   logic [63:0] prod_raw, prod_fix, hilo_new;

`ifdef MULT_ACC_EN
   logic        acc_q;
`else
   logic        unused_acc;
   assign unused_acc = ACC;
`endif

   // Operand conditioning: magnitudes for signed ops. 0x80000000 maps to
   // itself, which is the correct unsigned magnitude 2^31.
   always_comb begin
      op1_d = (SIGNED & RS[31]) ? (~RS + 32'd1) : RS;
      op2_d = (SIGNED & RT[31]) ? (~RT + 32'd1) : RT;
      neg_d = SIGNED & (RS[31] ^ RT[31]);
   end

   // Sign correction of the settled array output, plus optional accumulate.
   always_comb begin
      prod_raw = {MUL_HI, MUL_LO};
      prod_fix = neg_q ? (~prod_raw + 64'd1) : prod_raw;
      hilo_new = prod_fix;
`ifdef MULT_ACC_EN
      if (acc_q) begin
         hilo_new = {hi_q, lo_q} + prod_fix;
      end
`endif
   end

   // Control FSM with registered outputs; FLUSH beats the final capture edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         neg_q   <= 1'b0;
         op1_q   <= 32'd0;
         op2_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULT_ACC_EN
         acc_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  op1_q   <= op1_d;
                  op2_q   <= op2_d;
                  neg_q   <= neg_d;
                  cnt_q   <= CntInit;
                  state_q <= StRun;
                  busy_q  <= 1'b1;
`ifdef MULT_ACC_EN
                  acc_q   <= ACC;
`endif
               end else begin
                  if (MTHI) hi_q <= WDATA;
                  if (MTLO) lo_q <= WDATA;
               end
            end
            StRun: begin
               if (FLUSH) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  hi_q    <= hilo_new[63:32];
                  lo_q    <= hilo_new[31:0];
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign MUL_OP1 = op1_q;
   assign MUL_OP2 = op2_q;
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Sequential front/back end for the combinational 32x32 gate-level multiplier MULT32.
- Upstream, it conditions operands: takes magnitudes for signed ops and holds them stable at the MULT32 inputs.
- It waits a fixed settle time for the ripple array, then captures the 64-bit product into the architectural HI/LO registers with sign correction.
- Also services MTHI/MTLO writes and produces BUSY for the pipeline interlock.

Parameters:
- LATENCY, 4, cycles MULT32 outputs need to settle after the operand registers change; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous reset, active-low.
- START  in  1  launch multiply with RS/RT; sampled only in IDLE.
- SIGNED  in  1  1 = MULT (two's complement), 0 = MULTU.
- RS  in  32  operand A.
- RT  in  32  operand B.
- FLUSH  in  1  abort an in-flight multiply.
- MTHI  in  1  write WDATA to HI.
- MTLO  in  1  write WDATA to LO.
- WDATA  in  32  move-to data.
- ACC  in  1  accumulate request; used only with MULT_ACC_EN.
- MUL_OP1  out  32  registered operand to MULT32 OP1.
- MUL_OP2  out  32  registered operand to MULT32 OP2.
- MUL_HI  in  32  MULT32 HI output.
- MUL_LO  in  32  MULT32 LO output.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- BUSY  out  1  multiply in flight.
- DONE  out  1  one-cycle pulse when HI/LO have been updated by a multiply.

Behaviour:
- Reset (RST_N low, asynchronous): HI, LO, MUL_OP1, MUL_OP2 = 0; BUSY = 0; DONE = 0; state = IDLE; counter = 0; neg flag = 0.
- States: IDLE, RUN.
- IDLE with START=1 at edge t:
  - MUL_OP1 <= (SIGNED & RS[31]) ? -RS : RS; MUL_OP2 likewise from RT.
  - neg <= SIGNED & (RS[31]^RT[31]).
  - counter <= LATENCY-1; state <= RUN; BUSY = 1 from t.
  - 0x80000000 negates to itself and is treated as unsigned magnitude 2^31; the result is still correct.
- RUN, counter != 0: counter decrements each edge.
- RUN, counter == 0 at an edge:
  - {HI,LO} <= neg ? (2^64 - {MUL_HI,MUL_LO}) : {MUL_HI,MUL_LO}, a 64-bit two's-complement negate.
  - State <= IDLE; BUSY drops; DONE = 1 for exactly the following cycle.
- Latency: START sampled at edge t gives HI/LO valid and DONE high after edge t+LATENCY.
- START while BUSY: ignored, no queueing. Upstream must stall on BUSY.
- START and MTHI/MTLO in the same IDLE cycle: START wins and the move is dropped.
- MTHI/MTLO in IDLE without START: the selected register <= WDATA at that edge.
- MTHI and MTLO together: both registers are written with WDATA.
- MTHI/MTLO while BUSY: ignored.
- FLUSH in RUN: state <= IDLE, BUSY drops next edge, HI/LO unchanged, no DONE.
- FLUSH in IDLE: no effect.
- FLUSH together with the final RUN edge (counter==0): FLUSH wins, no capture.
- MUL_OP1/MUL_OP2 hold their value until the next START; they are not cleared on completion.
- RST_N asserted mid-RUN: immediate return to reset values, no capture.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined:
  - ACC sampled with START.
  - At capture, {HI,LO} <= {HI,LO} + signed-corrected product (MADD/MADDU), 64-bit wrap-around, carry out of bit 63 discarded.
  - ACC=0 behaves as normal multiply.
- Undefined: ACC input ignored; capture always overwrites HI/LO.

Test Plan:
- Unsigned 3*3, LATENCY=4, START at edge 0: BUSY high edges 0-3; HI=0, LO=9 after edge 4; DONE high one cycle.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- Signed -1*-1: HI=0, LO=1. Signed -1*1: HI=LO=0xFFFFFFFF. Signed 0x80000000*2: HI=0xFFFFFFFF, LO=0.
- MTHI 0x12345678 then START 2*2 then START 5*5 during BUSY: HI=0, LO=4; second START produces no effect and no second DONE.
- Mid-RUN checks:
  - FLUSH at cycle 2 of RUN: HI/LO keep their prior MTLO value 0xA5A5A5A5; no DONE.
  - RST_N pulsed mid-RUN: all outputs 0 asynchronously.
- With MULT_ACC_EN: HI=0, LO=0xFFFFFFFF, signed ACC 1*1 gives HI=1, LO=0; then signed ACC -1*1 gives HI=0, LO=0xFFFFFFFF.
